// File: rtl/spi_pkg.sv
// Shared types for the parameterised SPI master: FSM states and the
// per-transfer configuration captured when a start is accepted.
package spi_pkg;

    // Storage widths for latched fields. DIV_W must not exceed
    // SPIM_DIV_MAX_W. NUM_CS is at most 8, so 3 select bits are enough.
    localparam int SPIM_DIV_MAX_W = 16;
    localparam int SPIM_CS_MAX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        FINISH,
        HOLD
    } spim_state_t;

    typedef struct packed {
        logic                      cpol;
        logic                      cpha;
        logic                      lsb_first;
        logic [SPIM_DIV_MAX_W-1:0] clk_div;
        logic [SPIM_CS_MAX_W-1:0]  cs_sel;
        logic                      hold_cs;
    } spim_cfg_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer. While enabled it counts 0..load and raises tick for
// one cycle on the last count, so ticks are load+1 cycles apart. Dropping
// en clears the count so every transfer starts with a full half-period.
module spi_sclk_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] load,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count and expiry pulse
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == load) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: DATA_W-bit words, runtime SCLK divider, all
// four CPOL/CPHA modes, MSB/LSB-first, NUM_CS selects, CS hold for bursts.
// Optional feature macro SPIM_LOOPBACK_EN adds a `loopback` input that
// samples the master's own mosi instead of miso.
// Timeline for half-period H: accept at cycle 0, CS low at cycle 1,
// SETUP H cycles, SHIFT 2*DATA_W*H cycles, FINISH H cycles, and done at
// cycle (2*DATA_W+2)*H+1.
module spi_master_param
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 1,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              hold_cs,
    input  logic              cs_release,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPIM_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    spim_state_t         state_q, state_d;
    spim_cfg_t           cfg_q, cfg_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                done_q, done_d;
    logic                tick, gen_en, rx_bit;
    logic                odd_edge, last_edge, do_sample, do_shift;

    // Out-of-range selects match no bit, so no CS is asserted.
    function automatic logic [NUM_CS-1:0] cs_dec(input logic [SPIM_CS_MAX_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (sel == SPIM_CS_MAX_W'(i)) v[i] = 1'b0;
        return v;
    endfunction

`ifdef SPIM_LOOPBACK_EN
    logic lb_q, lb_d;
    assign rx_bit = lb_q ? mosi_q : miso;
`else
    assign rx_bit = miso;
`endif

    assign gen_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == FINISH);

    spi_sclk_gen #(.W(SPIM_DIV_MAX_W)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (gen_en),
        .load (cfg_q.clk_div),
        .tick (tick)
    );

    // edge_q counts edges already made; the coming edge k = edge_q+1.
    assign odd_edge  = ~edge_q[0];
    assign last_edge = (edge_q == EW'(2 * DATA_W - 1));
    assign do_sample = cfg_q.cpha ? ~odd_edge : odd_edge;
    assign do_shift  = cfg_q.cpha ? (odd_edge && (edge_q != '0)) : (~odd_edge && ~last_edge);

    // Transfer FSM next-state and datapath
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
`ifdef SPIM_LOOPBACK_EN
        lb_d      = lb_q;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == IDLE) begin
                    sclk_d = cpol;
                    cs_n_d = '1;
                end else begin
                    cs_n_d = cs_dec(cfg_q.cs_sel);
                end
                if (start) begin
                    // Start wins over a coincident cs_release.
                    state_d         = SETUP;
                    cfg_d.cpol      = cpol;
                    cfg_d.cpha      = cpha;
                    cfg_d.lsb_first = lsb_first;
                    cfg_d.clk_div   = SPIM_DIV_MAX_W'(clk_div);
                    cfg_d.cs_sel    = SPIM_CS_MAX_W'(cs_sel);
                    cfg_d.hold_cs   = hold_cs;
                    tx_sh_d         = tx_data;
                    rx_sh_d         = '0;
                    edge_d          = '0;
                    sclk_d          = cpol;
                    mosi_d          = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    cs_n_d          = cs_dec(SPIM_CS_MAX_W'(cs_sel));
`ifdef SPIM_LOOPBACK_EN
                    lb_d            = loopback;
`endif
                end else if ((state_q == HOLD) && cs_release) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (do_sample)
                        rx_sh_d = cfg_q.lsb_first ? {rx_bit, rx_sh_q[DATA_W-1:1]}
                                                  : {rx_sh_q[DATA_W-2:0], rx_bit};
                    if (do_shift) begin
                        if (cfg_q.lsb_first) begin
                            tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
                            mosi_d  = tx_sh_q[1];
                        end else begin
                            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                            mosi_d  = tx_sh_q[DATA_W-2];
                        end
                    end
                    if (last_edge) state_d = FINISH;
                end
            end
            FINISH: begin
                if (tick) begin
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    if (cfg_q.hold_cs) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        cs_n_d  = '1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            cs_n_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPIM_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
`ifdef SPIM_LOOPBACK_EN
            lb_q      <= lb_d;
`endif
        end
    end

    assign tx_ready = (state_q == IDLE) || (state_q == HOLD);
    assign busy     = gen_en;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, NUM_CS=4) with a
// mode-aware SPI slave model driving miso and capturing mosi.
module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol, cpha, lsb_first, hold_cs, cs_release, start;
    logic [7:0] clk_div;
    logic [1:0] cs_sel;
    logic [7:0] tx_data;
    logic       tx_ready, busy, done, sclk, mosi, miso;
    logic [7:0] rx_data;
    logic [3:0] cs_n;
`ifdef SPIM_LOOPBACK_EN
    logic       loopback;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // slave model state
    logic       slv_en = 1'b0;
    logic       slv_cpol, slv_cpha, slv_lsb, slv_first, lead;
    logic [7:0] slv_tx, slv_rx;
    int         slv_bit, slv_n;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb_first  (lsb_first),
        .clk_div    (clk_div),
        .cs_sel     (cs_sel),
        .hold_cs    (hold_cs),
        .cs_release (cs_release),
        .start      (start),
        .tx_data    (tx_data),
`ifdef SPIM_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic bit_at(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    // Slave: samples mosi on its sampling edge, drives the next miso bit on the other
    always @(sclk) begin
        if (slv_en) begin
            lead = (sclk !== slv_cpol);
            if (lead ^ slv_cpha) begin
                if (slv_n == 0) slv_first = mosi;
                slv_rx = slv_lsb ? {mosi, slv_rx[7:1]} : {slv_rx[6:0], mosi};
                slv_n++;
            end else if (slv_bit < 8) begin
                miso = bit_at(slv_tx, slv_bit, slv_lsb);
                slv_bit++;
            end
        end
    end

    // One word; called #1 after a posedge, returns #1 after the done edge.
    task automatic xfer(input logic p, input logic h, input logic lsb, input logic [7:0] div,
                        input logic [1:0] sel, input logic hold, input logic [7:0] tx,
                        input logic [7:0] stx, input logic [7:0] exp_rx, input logic disturb);
        int n, exp_n, limit;
        logic [3:0] exp_cs;
        logic cs_bad;
        exp_n  = 18 * (int'(div) + 1) + 1;
        limit  = exp_n + 50;
        exp_cs = ~(4'b0001 << sel);
        slv_cpol = p; slv_cpha = h; slv_lsb = lsb; slv_tx = stx; slv_rx = '0; slv_n = 0;
        slv_first = 1'bx;
        if (!h) begin
            miso = bit_at(stx, 0, lsb);
            slv_bit = 1;
        end else begin
            slv_bit = 0;
        end
        cpol = p; cpha = h; lsb_first = lsb; clk_div = div; cs_sel = sel;
        hold_cs = hold; tx_data = tx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; slv_en = 1'b1; n = 1; cs_bad = 1'b0;
        chk("sclk_setup_idle", sclk, p);
        chk("busy_setup", busy, 1);
        chk("tx_ready_busy", tx_ready, 0);
        while (done !== 1'b1 && n < limit) begin
            if (cs_n !== exp_cs) cs_bad = 1'b1;
            if (disturb && n == 3) begin
                start = 1'b1; cpol = ~p; clk_div = 8'd7; tx_data = 8'h00;
            end
            if (disturb && n == 4) begin
                start = 1'b0; cpol = p; clk_div = div;
            end
            @(posedge clk); #1;
            n++;
        end
        slv_en = 1'b0;
        chk("cs_steady", cs_bad, 0);
        chk("done_cycle", n, exp_n);
        chk("rx_data", rx_data, exp_rx);
        chk("slave_got", slv_rx, tx);
        chk("sample_edges", slv_n, 8);
        chk("first_mosi", slv_first, lsb ? tx[0] : tx[7]);
        chk("ready_in_done", tx_ready, 1);
        chk("cs_in_done", cs_n, hold ? exp_cs : 4'hF);
    endtask

    initial begin
        logic done_seen;
        rst = 1'b1; cpol = 0; cpha = 0; lsb_first = 0; hold_cs = 0; cs_release = 0;
        start = 0; clk_div = 0; cs_sel = 0; tx_data = 0; miso = 0;
`ifdef SPIM_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_rx", rx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // mode 0, max rate
        xfer(0, 0, 0, 8'd0, 2'd0, 0, 8'hA5, 8'h3C, 8'h3C, 0);
        // modes 1..3, H=4; mode 1 also sees ignored start and config churn
        xfer(0, 1, 0, 8'd3, 2'd1, 0, 8'h81, 8'h5B, 8'h5B, 1);
        xfer(1, 0, 0, 8'd3, 2'd3, 0, 8'h81, 8'hC6, 8'hC6, 0);
        xfer(1, 1, 0, 8'd3, 2'd0, 0, 8'h81, 8'h2D, 8'h2D, 0);
        // LSB first, H=2
        xfer(0, 0, 1, 8'd1, 2'd0, 0, 8'h12, 8'hEF, 8'hEF, 0);

        // idle sclk tracks live cpol
        cpol = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk_cpol1", sclk, 1);
        cpol = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk_cpol0", sclk, 0);

        // burst on cs 2 with CS held, back-to-back, then release
        xfer(0, 0, 0, 8'd0, 2'd2, 1, 8'hC3, 8'h96, 8'h96, 0);
        xfer(0, 0, 0, 8'd0, 2'd2, 1, 8'h5A, 8'hF0, 8'hF0, 0);
        @(posedge clk); #1;
        chk("hold_cs_n", cs_n, 4'b1011);
        chk("hold_ready", tx_ready, 1);
        cs_release = 1'b1;
        @(posedge clk); #1;
        cs_release = 1'b0;
        chk("release_cs_n", cs_n, 4'hF);
        chk("release_busy", busy, 0);

        // reset in the middle of a transfer
        cpol = 0; cpha = 0; lsb_first = 0; clk_div = 0; cs_sel = 2'd1; hold_cs = 0;
        tx_data = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_cs_n", cs_n, 4'hF);
        chk("mid_rst_rx", rx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        chk("no_done_after_rst", done_seen, 0);

        // recovery transfer, mode 3 LSB first
        xfer(1, 1, 1, 8'd0, 2'd1, 0, 8'hE7, 8'h18, 8'h18, 0);

`ifdef SPIM_LOOPBACK_EN
        loopback = 1'b1;
        xfer(0, 0, 0, 8'd0, 2'd0, 0, 8'h5A, 8'h00, 8'h5A, 0);
        loopback = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
